rr_bus_mux: RTL and testbench
=============================

Name: rr_bus_mux

Overview:
- Parametrised, registered N-channel bus multiplexer with per-channel valid/ready handshake and an output register.
- Two selection modes: fixed select (mux behaviour) and round-robin arbitration.
- Sits between the register bank or functional units and the shared datapath bus.
- Replaces purely combinational 16:1 bus selection where several sources contend for the bus.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 16, number of input channels (2..64; need not be a power of 2).
- SELW, $clog2(NCH), width of channel index fields (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NCH  per-channel request; bit i belongs to channel i.
- in_data  input  NCH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used when mode=0.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts out_data.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. The in_ready outputs are combinational and evaluate to all 0 while rst=1.
- load_en = !out_valid || out_ready. The output register may be refilled in the same cycle it is drained.
- Grant, combinational:
  - mode=0: grant = sel if sel<NCH and in_valid[sel]; otherwise no grant. sel>=NCH never grants.
  - mode=1: first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... NCH-1, 0, ... rr_ptr-1 (wraps at NCH, not at 2^SELW).
- in_ready[i] = load_en && grant_any && grant==i. in_ready does not assert for a channel with in_valid=0.
- Transfer on channel i: in_valid[i] && in_ready[i]. At the next posedge: out_data<=in_data[i], out_ch<=i, out_valid<=1.
- Drain without refill: load_en && !grant_any -> out_valid<=0 next edge. out_data and out_ch hold their stale values.
- Stall: out_valid && !out_ready -> out_data and out_ch hold, and all in_ready are 0.
- rr_ptr:
  - Updates only on a mode=1 transfer: rr_ptr <= (grant==NCH-1) ? 0 : grant+1.
  - mode=0 transfers leave rr_ptr unchanged.
- Latency: 1 cycle from in_valid&&in_ready to out_valid. Throughput: 1 word/cycle while out_ready=1.
- Mode or sel change: affects only the next grant decision. A word already in the output register is never altered.
- Reset mid-transfer: the word is discarded. Sources must re-present it after reset.
- Fairness: with all NCH channels continuously valid in mode=1, each channel is granted exactly once per NCH transfers.

Decomposition:
- Package rr_bus_pkg:
  - localparam MODE_FIXED=1'b0, MODE_RR=1'b1.
  - A function for next-pointer wrap at NCH.
- Sub-module rr_arbiter (parameters NCH, SELW): inputs req[NCH], ptr; outputs gnt_any, gnt_idx.
  - Purely combinational rotate-priority search, unit-testable on its own.
- rr_bus_mux holds the output register, rr_ptr, mode/sel mux and handshake logic.

Test Plan (WIDTH=8, NCH=16 unless stated):
- Fixed mode: mode=0, sel=5, in_valid=16'h0020, ch5 data=8'hA5, out_ready=1 -> in_ready=16'h0020; next cycle out_valid=1, out_data=A5, out_ch=5; rr_ptr stays 0.
- Round-robin: mode=1, in_valid=16'h8421 held, out_ready=1 -> out_ch sequence 0,5,10,15,0,5, one per cycle, no bubbles.
- Backpressure: out_valid=1 with out_ch=3, out_ready=0 for 4 cycles, ch7 valid -> in_ready=0 and outputs hold for all 4 cycles. Then raise out_ready -> ch7 transfers that cycle; next cycle out_ch=7.
- Boundary:
  - mode=0, sel=15, only ch15 valid -> granted.
  - NCH=10 build, mode=1, rr_ptr=9, in_valid=10'h201 -> grants 9 then 0 (wrap at 10).
  - NCH=10, mode=0, sel=12 -> no grant.
- Empty drain: single transfer then in_valid=0, out_ready=1 -> out_valid falls one cycle after rising; out_data keeps its last value.
- Async reset: assert rst mid-cycle while out_valid=1 -> out_valid, out_data, out_ch and rr_ptr become 0 immediately, without waiting for clk; in_ready all 0 while rst=1.

Source files
------------

// File: rtl/rr_bus_pkg.sv
// Shared constants and helpers for the registered round-robin bus multiplexer.
package rr_bus_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // The pointer wraps at the channel count, not at the index field width.
  function automatic int unsigned rr_next_ptr(input int unsigned idx, input int unsigned nch);
    return (idx == nch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or after ptr, wrapping at NCH.
module rr_arbiter #(
  parameter int unsigned NCH  = 16,
  parameter int unsigned SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_any,
  output logic [SELW-1:0] gnt_idx
);

  localparam int unsigned IW = SELW + 1;

  logic [IW-1:0] idx;

  // One extra bit holds ptr+k before the modulo-NCH fold.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      idx = {1'b0, ptr} + IW'(k);
      if (idx >= IW'(NCH)) idx = idx - IW'(NCH);
      if (!gnt_any && req[idx[SELW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_bus_mux.sv
// N-channel registered bus multiplexer with fixed-select and round-robin modes
// and a valid/ready handshake on every channel and on the output register.
module rr_bus_mux
  import rr_bus_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 16,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] ch_data [NCH];
  logic [SELW-1:0]  rr_ptr;
  logic             rr_any;
  logic [SELW-1:0]  rr_idx;
  logic             fixed_any;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic             load_en;
  logic             xfer;

  for (genvar i = 0; i < int'(NCH); i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_any (rr_any),
    .gnt_idx (rr_idx)
  );

  // Out-of-range select never grants, even when the index field could address it.
  always_comb begin
    fixed_any = 1'b0;
    if (32'(sel) < 32'(NCH)) fixed_any = in_valid[sel];
  end

  assign grant_any = (mode == MODE_FIXED) ? fixed_any : rr_any;
  assign grant_idx = (mode == MODE_FIXED) ? sel       : rr_idx;
  assign load_en   = !out_valid || out_ready;
  assign xfer      = load_en && grant_any && !rst;
  assign in_ready  = xfer ? (NCH'(1) << grant_idx) : '0;

  // Output register and round-robin pointer; drain without refill leaves data/ch stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[grant_idx];
        out_ch    <= grant_idx;
        if (mode == MODE_RR) rr_ptr <= SELW'(rr_next_ptr(32'(grant_idx), NCH));
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed testbench for rr_bus_mux: a 16-channel instance and a 10-channel instance.
module tb_rr_bus_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [15:0]  in_valid16 = '0;
  logic [127:0] in_data16  = '0;
  logic [15:0]  in_ready16;
  logic         mode16 = 1'b0;
  logic [3:0]   sel16  = '0;
  logic         out_valid16;
  logic [7:0]   out_data16;
  logic [3:0]   out_ch16;
  logic         out_ready16 = 1'b1;

  logic [9:0]   in_valid10 = '0;
  logic [79:0]  in_data10  = '0;
  logic [9:0]   in_ready10;
  logic         mode10 = 1'b0;
  logic [3:0]   sel10  = '0;
  logic         out_valid10;
  logic [7:0]   out_data10;
  logic [3:0]   out_ch10;
  logic         out_ready10 = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_bus_mux #(.WIDTH(8), .NCH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_data(in_data16), .in_ready(in_ready16),
    .mode(mode16), .sel(sel16), .out_valid(out_valid16), .out_data(out_data16),
    .out_ch(out_ch16), .out_ready(out_ready16)
  );

  rr_bus_mux #(.WIDTH(8), .NCH(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid10), .in_data(in_data10), .in_ready(in_ready10),
    .mode(mode10), .sel(sel10), .out_valid(out_valid10), .out_data(out_data10),
    .out_ch(out_ch10), .out_ready(out_ready10)
  );

  task automatic test_reset();
    mode16 = 1'b1; in_valid16 = 16'hFFFF;
    #2;
    n_checks++; if (out_valid16 !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid16); end
    n_checks++; if (out_data16 !== 8'h00) begin n_errors++; $display("FAIL reset_out_data got %h exp 00", out_data16); end
    n_checks++; if (out_ch16 !== 4'd0) begin n_errors++; $display("FAIL reset_out_ch got %0d exp 0", out_ch16); end
    n_checks++; if (dut.rr_ptr !== 4'd0) begin n_errors++; $display("FAIL reset_rr_ptr got %0d exp 0", dut.rr_ptr); end
    n_checks++; if (in_ready16 !== 16'h0000) begin n_errors++; $display("FAIL reset_in_ready got %h exp 0000", in_ready16); end
    @(negedge clk);
    rst = 1'b0; in_valid16 = '0; mode16 = 1'b0;
  endtask

  task automatic test_fixed();
    @(negedge clk);
    mode16 = 1'b0; sel16 = 4'd5; in_valid16 = 16'h0020; out_ready16 = 1'b1;
    #1;
    n_checks++; if (in_ready16 !== 16'h0020) begin n_errors++; $display("FAIL fixed_in_ready got %h exp 0020", in_ready16); end
    @(posedge clk); #1;
    n_checks++; if (out_valid16 !== 1'b1) begin n_errors++; $display("FAIL fixed_out_valid got %b exp 1", out_valid16); end
    n_checks++; if (out_data16 !== 8'hA5) begin n_errors++; $display("FAIL fixed_out_data got %h exp a5", out_data16); end
    n_checks++; if (out_ch16 !== 4'd5) begin n_errors++; $display("FAIL fixed_out_ch got %0d exp 5", out_ch16); end
    n_checks++; if (dut.rr_ptr !== 4'd0) begin n_errors++; $display("FAIL fixed_rr_ptr got %0d exp 0", dut.rr_ptr); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ch [6];
    logic [7:0] exp_d;
    exp_ch = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd0, 4'd5};
    @(negedge clk);
    mode16 = 1'b1; in_valid16 = 16'h8421;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_d = (exp_ch[i] == 4'd5) ? 8'hA5 : 8'h10 + 8'(exp_ch[i]);
      n_checks++; if (out_valid16 !== 1'b1 || out_ch16 !== exp_ch[i] || out_data16 !== exp_d) begin
        n_errors++; $display("FAIL rr_step%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", i, out_valid16, out_ch16, out_data16, exp_ch[i], exp_d);
      end
    end
    n_checks++; if (dut.rr_ptr !== 4'd6) begin n_errors++; $display("FAIL rr_ptr_after got %0d exp 6", dut.rr_ptr); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    mode16 = 1'b0; sel16 = 4'd3; in_valid16 = 16'h0008; out_ready16 = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_ch16 !== 4'd3) begin n_errors++; $display("FAIL bp_setup_ch got %0d exp 3", out_ch16); end
    @(negedge clk);
    out_ready16 = 1'b0; sel16 = 4'd7; in_valid16 = 16'h0080;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (in_ready16 !== 16'h0000) begin n_errors++; $display("FAIL bp_in_ready%0d got %h exp 0000", i, in_ready16); end
      @(posedge clk); #1;
      n_checks++; if (out_valid16 !== 1'b1 || out_ch16 !== 4'd3 || out_data16 !== 8'h13) begin
        n_errors++; $display("FAIL bp_hold%0d got v=%b ch=%0d d=%h exp v=1 ch=3 d=13", i, out_valid16, out_ch16, out_data16);
      end
      @(negedge clk);
    end
    out_ready16 = 1'b1;
    #1;
    n_checks++; if (in_ready16 !== 16'h0080) begin n_errors++; $display("FAIL bp_release_in_ready got %h exp 0080", in_ready16); end
    @(posedge clk); #1;
    n_checks++; if (out_ch16 !== 4'd7 || out_data16 !== 8'h17) begin
      n_errors++; $display("FAIL bp_release_out got ch=%0d d=%h exp ch=7 d=17", out_ch16, out_data16);
    end
  endtask

  task automatic test_fixed_top_and_drain();
    @(negedge clk);
    mode16 = 1'b0; sel16 = 4'd15; in_valid16 = 16'h8000;
    #1;
    n_checks++; if (in_ready16 !== 16'h8000) begin n_errors++; $display("FAIL sel15_in_ready got %h exp 8000", in_ready16); end
    @(posedge clk); #1;
    n_checks++; if (out_valid16 !== 1'b1 || out_ch16 !== 4'd15 || out_data16 !== 8'h1F) begin
      n_errors++; $display("FAIL sel15_out got v=%b ch=%0d d=%h exp v=1 ch=15 d=1f", out_valid16, out_ch16, out_data16);
    end
    @(negedge clk);
    in_valid16 = 16'h0000;
    #1;
    n_checks++; if (in_ready16 !== 16'h0000) begin n_errors++; $display("FAIL drain_in_ready got %h exp 0000", in_ready16); end
    @(posedge clk); #1;
    n_checks++; if (out_valid16 !== 1'b0 || out_ch16 !== 4'd15 || out_data16 !== 8'h1F) begin
      n_errors++; $display("FAIL drain_out got v=%b ch=%0d d=%h exp v=0 ch=15 d=1f", out_valid16, out_ch16, out_data16);
    end
  endtask

  task automatic test_nch10();
    @(negedge clk);
    mode10 = 1'b1; in_valid10 = 10'h100;
    @(posedge clk); #1;
    n_checks++; if (out_ch10 !== 4'd8 || dut10.rr_ptr !== 4'd9) begin
      n_errors++; $display("FAIL n10_setup got ch=%0d ptr=%0d exp ch=8 ptr=9", out_ch10, dut10.rr_ptr);
    end
    @(negedge clk);
    in_valid10 = 10'h201;
    #1;
    n_checks++; if (in_ready10 !== 10'h200) begin n_errors++; $display("FAIL n10_gnt9 got %h exp 200", in_ready10); end
    @(posedge clk); #1;
    n_checks++; if (out_ch10 !== 4'd9 || out_data10 !== 8'h39 || dut10.rr_ptr !== 4'd0) begin
      n_errors++; $display("FAIL n10_out9 got ch=%0d d=%h ptr=%0d exp ch=9 d=39 ptr=0", out_ch10, out_data10, dut10.rr_ptr);
    end
    @(negedge clk); #1;
    n_checks++; if (in_ready10 !== 10'h001) begin n_errors++; $display("FAIL n10_gnt0 got %h exp 001", in_ready10); end
    @(posedge clk); #1;
    n_checks++; if (out_ch10 !== 4'd0 || out_data10 !== 8'h30) begin
      n_errors++; $display("FAIL n10_out0 got ch=%0d d=%h exp ch=0 d=30", out_ch10, out_data10);
    end
    @(negedge clk);
    mode10 = 1'b0; sel10 = 4'd12; in_valid10 = 10'h3FF;
    #1;
    n_checks++; if (in_ready10 !== 10'h000) begin n_errors++; $display("FAIL n10_sel12_ready got %h exp 000", in_ready10); end
    @(posedge clk); #1;
    n_checks++; if (out_valid10 !== 1'b0) begin n_errors++; $display("FAIL n10_sel12_valid got %b exp 0", out_valid10); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    mode16 = 1'b1; in_valid16 = 16'h0400;
    @(posedge clk); #1;
    n_checks++; if (out_valid16 !== 1'b1 || out_ch16 !== 4'd10 || dut.rr_ptr !== 4'd11) begin
      n_errors++; $display("FAIL ar_setup got v=%b ch=%0d ptr=%0d exp v=1 ch=10 ptr=11", out_valid16, out_ch16, dut.rr_ptr);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid16 !== 1'b0 || out_data16 !== 8'h00 || out_ch16 !== 4'd0 || dut.rr_ptr !== 4'd0) begin
      n_errors++; $display("FAIL ar_clear got v=%b d=%h ch=%0d ptr=%0d exp all 0", out_valid16, out_data16, out_ch16, dut.rr_ptr);
    end
    n_checks++; if (in_ready16 !== 16'h0000) begin n_errors++; $display("FAIL ar_in_ready got %h exp 0000", in_ready16); end
    @(negedge clk);
    rst = 1'b0; in_valid16 = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) in_data16[i*8 +: 8] = 8'h10 + 8'(i);
    in_data16[5*8 +: 8] = 8'hA5;
    for (int i = 0; i < 10; i++) in_data10[i*8 +: 8] = 8'h30 + 8'(i);
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_fixed_top_and_drain();
    test_nch10();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
